disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Scheduler that shares the board's single 4-digit seven-segment display among up to `N_REQ` requesters, such as the debounce event counters and status readouts. Each requester presents a 16-bit hex value and a 4-bit decimal-point pattern with a level request. The block grants one owner at a time in round-robin order and enforces a minimum on-screen hold time. Its registered outputs drive the `hex3..hex0`/`dp_in` inputs of the existing `disp_hex_mux`.

## Interface
- `N_REQ`, 4: number of requesters, legal range 2..8
- `HOLD_CYCLES`, 100_000_000: minimum ownership in clk cycles (1 s at 100 MHz), must be ≥ 2
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `req`  input  N_REQ  level request per requester
- `data`  input  16*N_REQ  requester i value at bits [16i+15:16i]
- `dp`  input  4*N_REQ  requester i dp pattern at bits [4i+3:4i]
- `gnt`  output  N_REQ  one-hot current owner, all zero when idle
- `hex3`, `hex2`, `hex1`, `hex0`  output  4 each  owner data nibbles [15:12]..[3:0]
- `dp_out`  output  4  owner dp pattern
- `active`  output  1  high while any owner is granted
- `switch_tick`  output  1  one-cycle pulse in the first cycle of each new grant

## Operation
- States: `IDLE` (no owner) and `OWN` (owner held in `gnt`).
- `hold_cnt` clears to 0 on every new grant. It increments each cycle in `OWN` and saturates at `HOLD_CYCLES-1`. Width is `$clog2(HOLD_CYCLES)`.
- Round-robin pick: search the requesters starting at `last+1` and wrap modulo `N_REQ`. Select the first with `req` high, excluding the current owner. `last` updates on every grant and resets to `N_REQ-1`, so requester 0 wins first.
- `IDLE` with any `req` high → `OWN`, granting the pick.
- `OWN`, owner `req` low → re-arbitrate in the same cycle. If another request is pending, grant it directly with no `IDLE` cycle, whatever `hold_cnt` is. If none, go to `IDLE`.
- `OWN`, owner `req` high, `hold_cnt == HOLD_CYCLES-1`, other request pending → grant the pick.
- `OWN`, owner `req` high, no other pending → keep the owner indefinitely; the counter stays saturated.
- Display outputs track the owner's live `data`/`dp`, registered, so counter updates appear while the owner holds the display.
- When idle: `hex*` = 0, `dp_out` = 4'b0000, `active` = 0.
- `switch_tick` asserts with each `gnt` change to a non-zero value, including `IDLE`→`OWN`.

## Timing
- Reset, asynchronous and active-low: `gnt`=0, `hex*`=0, `dp_out`=0, `active`=0, `switch_tick`=0, `hold_cnt`=0, state `IDLE`, `last`=`N_REQ-1`. Reset asserted mid-ownership clears all of these immediately.
- `req` is sampled at the rising edge. `gnt`, `active` and `switch_tick` change on the next edge, giving 1-cycle latency.
- `hex*` and `dp_out` reflect `data`/`dp` of the owner granted in the same cycle, with 1-cycle latency from `data`. The first cycle of a grant already shows the new owner's data.
- Minimum ownership is exactly `HOLD_CYCLES` cycles unless the owner releases early.
- Owner release and another request arriving in the same cycle: the other request wins on the next edge.
- Multiple new requests in the same cycle: round-robin order decides.

## Configuration
- `DISP_ARB_PRIO_EN` defined: requester 0 has preemptive priority. Whenever `req[0]` is high and requester 0 is not the owner, it is granted on the next edge, ignoring `hold_cnt`. `last` is not updated by a priority grant. While requester 0 owns the display, the others still wait for `HOLD_CYCLES`.
- Undefined: pure round-robin with hold, as above.

## Structure
- Package `disp_arb_pkg`:
  - state enum `{IDLE, OWN}`
  - `DISP_ARB_HOLD_DEFAULT` constant
  - idle dp constant `4'b0000`
- Sub-module `rr_pick`: combinational. Takes `req`, the exclusion mask and the base pointer `last`; returns a one-hot pick and a `valid` flag. Parameterised by `N_REQ`.
- The top level holds the FSM, `hold_cnt`, `last`, the output mux and output registers.

## Test plan
Bench uses `N_REQ`=4, `HOLD_CYCLES`=8.
- Reset released, `req`=4'b0000 for 10 cycles → `gnt`=0, `active`=0, `hex*`=0, no `switch_tick`.
- `req`=4'b0110 raised together → one cycle later `gnt`=4'b0010 with `switch_tick`. Exactly 8 cycles later `gnt`=4'b0100.
- Single `req[3]` held 50 cycles, `data[63:48]`=16'hBEEF incremented mid-hold → `gnt`=4'b1000 throughout, `hex3..hex0` follow the new value one cycle after each change.
- Owner 1 drops `req` at `hold_cnt`=3 while `req[2]` is pending → `gnt`=4'b0100 next edge, no idle cycle.
- Reset asserted while `gnt`=4'b0100 → `gnt`, `active`, `hex*` clear without waiting for a clock. After release with `req`=4'b1111 → `gnt`=4'b0001.
- `DISP_ARB_PRIO_EN`: owner 2 at `hold_cnt`=1, raise `req[0]` → `gnt`=4'b0001 next edge.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Optional feature macro: DISP_ARB_PRIO_EN (requester 0 preemptive priority).
package disp_arb_pkg;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_e;

    localparam int unsigned DISP_ARB_HOLD_DEFAULT = 100_000_000;
    localparam logic [3:0]  DISP_ARB_IDLE_DP      = 4'b0000;

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last (wrapping),
// skipping any requester set in i_excl.
module rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_excl,
    input  logic [$clog2(N_REQ)-1:0] i_last,
    output logic [N_REQ-1:0]         o_pick,
    output logic                     o_valid
);

    localparam int unsigned LW = $clog2(N_REQ);

    logic [31:0]   w_sum;
    logic [31:0]   w_mod;
    logic [LW-1:0] w_idx;

    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_mod   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = 32'(i_last) + 32'(k);
            w_mod = w_sum % N_REQ;
            w_idx = w_mod[LW-1:0];
            if (!o_valid && i_req[w_idx] && !i_excl[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner scheduler for the shared 4-digit display with a minimum hold time.
// Define DISP_ARB_PRIO_EN to give requester 0 preemptive priority.
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = DISP_ARB_HOLD_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [16*N_REQ-1:0] i_data,
    input  logic [4*N_REQ-1:0]  i_dp,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [3:0]          o_hex3,
    output logic [3:0]          o_hex2,
    output logic [3:0]          o_hex1,
    output logic [3:0]          o_hex0,
    output logic [3:0]          o_dp_out,
    output logic                o_active,
    output logic                o_switch_tick
);

    localparam int unsigned LW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);

    arb_state_e     r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [CW-1:0]  r_hold_cnt;
    logic [LW-1:0]  r_last;
    logic [15:0]    r_disp;
    logic [3:0]     r_dp;
    logic           r_active;
    logic           r_switch_tick;

    arb_state_e     w_state_d;
    logic [N_REQ-1:0] w_gnt_d;
    logic [CW-1:0]  w_hold_cnt_d;
    logic [LW-1:0]  w_last_d;
    logic [15:0]    w_disp_d;
    logic [3:0]     w_dp_d;
    logic           w_grant;
    logic           w_owner_req;
    logic           w_hold_done;
    logic [N_REQ-1:0] w_pick;
    logic           w_valid;
    logic [LW-1:0]  w_pick_idx;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_excl  (r_gnt),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_valid (w_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = LW'(i);
            end
        end
    end

    assign w_owner_req = |(i_req & r_gnt);
    assign w_hold_done = (r_hold_cnt == HOLD_MAX);

    always_comb begin
        w_state_d    = r_state;
        w_gnt_d      = r_gnt;
        w_hold_cnt_d = r_hold_cnt;
        w_last_d     = r_last;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_grant = 1'b1;
                end
            end
            OWN: begin
                if (!w_owner_req) begin
                    // Release hands over directly, regardless of the hold counter.
                    if (w_valid) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_d    = IDLE;
                        w_gnt_d      = '0;
                        w_hold_cnt_d = '0;
                    end
                end else if (w_hold_done && w_valid) begin
                    w_grant = 1'b1;
                end else if (!w_hold_done) begin
                    w_hold_cnt_d = r_hold_cnt + CW'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_gnt_d   = '0;
            end
        endcase
        if (w_grant) begin
            w_state_d    = OWN;
            w_gnt_d      = w_pick;
            w_hold_cnt_d = '0;
            w_last_d     = w_pick_idx;
        end
`ifdef DISP_ARB_PRIO_EN
        // Priority grant leaves the round-robin pointer untouched.
        if (i_req[0] && !r_gnt[0]) begin
            w_grant      = 1'b1;
            w_state_d    = OWN;
            w_gnt_d      = N_REQ'(1);
            w_hold_cnt_d = '0;
            w_last_d     = r_last;
        end
`endif
    end

    always_comb begin
        w_disp_d = '0;
        w_dp_d   = DISP_ARB_IDLE_DP;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_d[i]) begin
                w_disp_d = w_disp_d | i_data[16*i +: 16];
                w_dp_d   = w_dp_d | i_dp[4*i +: 4];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_hold_cnt    <= '0;
            r_last        <= LAST_RST;
            r_disp        <= '0;
            r_dp          <= DISP_ARB_IDLE_DP;
            r_active      <= 1'b0;
            r_switch_tick <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_gnt         <= w_gnt_d;
            r_hold_cnt    <= w_hold_cnt_d;
            r_last        <= w_last_d;
            r_disp        <= w_disp_d;
            r_dp          <= w_dp_d;
            r_active      <= |w_gnt_d;
            r_switch_tick <= w_grant;
        end
    end

    assign o_gnt         = r_gnt;
    assign o_hex3        = r_disp[15:12];
    assign o_hex2        = r_disp[11:8];
    assign o_hex1        = r_disp[7:4];
    assign o_hex0        = r_disp[3:0];
    assign o_dp_out      = r_dp;
    assign o_active      = r_active;
    assign o_switch_tick = r_switch_tick;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter (N_REQ=4, HOLD_CYCLES=8).
module tb_disp_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] data;
    logic [15:0] dp;
    logic [3:0]  gnt;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_out;
    logic        active;
    logic        switch_tick;

    int n_checks = 0;
    int n_pass   = 0;

    disp_arbiter #(
        .N_REQ       (4),
        .HOLD_CYCLES (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_data        (data),
        .i_dp          (dp),
        .o_gnt         (gnt),
        .o_hex3        (hex3),
        .o_hex2        (hex2),
        .o_hex1        (hex1),
        .o_hex0        (hex0),
        .o_dp_out      (dp_out),
        .o_active      (active),
        .o_switch_tick (switch_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step(2);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            n_checks++;
            if ({gnt, active, switch_tick, hex3, hex2, hex1, hex0, dp_out} !== 27'd0)
                $display("FAIL reset_idle cyc %0d: gnt=%b act=%b tick=%b hex=%h dp=%b req 0",
                         c, gnt, active, switch_tick, {hex3, hex2, hex1, hex0}, dp_out);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        req = 4'b0110;
        step(1);
        n_checks++;
        if ({gnt, switch_tick, active} !== 6'b0010_1_1)
            $display("FAIL rr_first: gnt=%b tick=%b act=%b want 0010 1 1", gnt, switch_tick, active);
        else n_pass++;
        n_checks++;
        if ({hex3, hex2, hex1, hex0, dp_out} !== {16'h5678, 4'b0010})
            $display("FAIL rr_first_disp: hex=%h dp=%b want 5678 0010",
                     {hex3, hex2, hex1, hex0}, dp_out);
        else n_pass++;
        step(1);
        n_checks++;
        if ({gnt, switch_tick} !== 5'b0010_0)
            $display("FAIL rr_tick_pulse: gnt=%b tick=%b want 0010 0", gnt, switch_tick);
        else n_pass++;
        step(6);
        n_checks++;
        if (gnt !== 4'b0010)
            $display("FAIL rr_hold_min: gnt=%b want 0010", gnt);
        else n_pass++;
        step(1);
        n_checks++;
        if ({gnt, switch_tick} !== 5'b0100_1)
            $display("FAIL rr_switch: gnt=%b tick=%b want 0100 1", gnt, switch_tick);
        else n_pass++;
        n_checks++;
        if ({hex3, hex2, hex1, hex0, dp_out} !== {16'h9ABC, 4'b0100})
            $display("FAIL rr_switch_disp: hex=%h dp=%b want 9abc 0100",
                     {hex3, hex2, hex1, hex0}, dp_out);
        else n_pass++;
        req = 4'b0000;
        step(1);
        n_checks++;
        if ({gnt, active, hex3, hex2, hex1, hex0, dp_out} !== 25'd0)
            $display("FAIL rr_to_idle: gnt=%b act=%b hex=%h dp=%b want all 0",
                     gnt, active, {hex3, hex2, hex1, hex0}, dp_out);
        else n_pass++;
    endtask

    task automatic test_hold_single();
        req = 4'b1000;
        step(1);
        n_checks++;
        if ({gnt, switch_tick, hex3, hex2, hex1, hex0} !== {4'b1000, 1'b1, 16'hBEEF})
            $display("FAIL single_grant: gnt=%b tick=%b hex=%h want 1000 1 beef",
                     gnt, switch_tick, {hex3, hex2, hex1, hex0});
        else n_pass++;
        for (int c = 1; c < 50; c++) begin
            if (c == 20) data[63:48] = 16'hBEF0;
            if (c == 35) data[63:48] = 16'hBEF1;
            step(1);
            if (c == 20 || c == 35 || c == 49) begin
                n_checks++;
                if ({gnt, switch_tick, hex3, hex2, hex1, hex0} !== {4'b1000, 1'b0, data[63:48]})
                    $display("FAIL single_follow cyc %0d: gnt=%b tick=%b hex=%h want 1000 0 %h",
                             c, gnt, switch_tick, {hex3, hex2, hex1, hex0}, data[63:48]);
                else n_pass++;
            end
        end
        req = 4'b0000;
        step(1);
    endtask

    task automatic test_early_release();
        req = 4'b0110;
        step(1);
        n_checks++;
        if (gnt !== 4'b0010)
            $display("FAIL early_first: gnt=%b want 0010", gnt);
        else n_pass++;
        step(3);
        n_checks++;
        if (gnt !== 4'b0010)
            $display("FAIL early_held: gnt=%b want 0010", gnt);
        else n_pass++;
        req = 4'b0100;
        step(1);
        n_checks++;
        if ({gnt, switch_tick, active} !== 6'b0100_1_1)
            $display("FAIL early_handover: gnt=%b tick=%b act=%b want 0100 1 1",
                     gnt, switch_tick, active);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, active, switch_tick, hex3, hex2, hex1, hex0, dp_out} !== 27'd0)
            $display("FAIL async_reset: gnt=%b act=%b tick=%b hex=%h dp=%b want all 0",
                     gnt, active, switch_tick, {hex3, hex2, hex1, hex0}, dp_out);
        else n_pass++;
        req = 4'b1111;
        step(1);
        rst_n = 1'b1;
        step(1);
        n_checks++;
        if ({gnt, switch_tick, hex3, hex2, hex1, hex0} !== {4'b0001, 1'b1, 16'h1234})
            $display("FAIL reset_restart: gnt=%b tick=%b hex=%h want 0001 1 1234",
                     gnt, switch_tick, {hex3, hex2, hex1, hex0});
        else n_pass++;
    endtask

`ifdef DISP_ARB_PRIO_EN
    task automatic test_prio();
        rst_n = 1'b0;
        req   = 4'b0000;
        step(1);
        rst_n = 1'b1;
        req   = 4'b0100;
        step(1);
        n_checks++;
        if (gnt !== 4'b0100)
            $display("FAIL prio_owner2: gnt=%b want 0100", gnt);
        else n_pass++;
        step(1);
        req = 4'b0101;
        step(1);
        n_checks++;
        if ({gnt, switch_tick} !== 5'b0001_1)
            $display("FAIL prio_preempt: gnt=%b tick=%b want 0001 1", gnt, switch_tick);
        else n_pass++;
        step(7);
        n_checks++;
        if (gnt !== 4'b0001)
            $display("FAIL prio_hold: gnt=%b want 0001", gnt);
        else n_pass++;
        step(1);
        n_checks++;
        if (gnt !== 4'b0100)
            $display("FAIL prio_rr_after: gnt=%b want 0100", gnt);
        else n_pass++;
        step(1);
        n_checks++;
        if (gnt !== 4'b0001)
            $display("FAIL prio_repreempt: gnt=%b want 0001", gnt);
        else n_pass++;
    endtask
`else
    task automatic test_back_to_back();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            step(7);
            n_checks++;
            if (switch_tick !== 1'b0)
                $display("FAIL b2b_no_tick %0d: tick=%b want 0", s, switch_tick);
            else n_pass++;
            step(1);
            n_checks++;
            if ({gnt, switch_tick} !== {exp_seq[s], 1'b1})
                $display("FAIL b2b_rotate %0d: gnt=%b tick=%b want %b 1",
                         s, gnt, switch_tick, exp_seq[s]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        data  = {16'hBEEF, 16'h9ABC, 16'h5678, 16'h1234};
        dp    = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        test_reset();
        test_round_robin();
        test_hold_single();
        test_early_release();
        test_reset_mid();
`ifdef DISP_ARB_PRIO_EN
        test_prio();
`else
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
